uart_tx_frame_gen: RTL
======================

# uart_tx_frame_gen

Synthesizable, parametrised UART frame transmitter with a byte FIFO, programmable baud divisor, data width, parity mode and stop-bit count. Each queued word can carry a fault flag that corrupts its parity bit or its stop bit, for link and receiver error-path testing. Sits on the SoC peripheral side. Also instantiated in benches as a cycle-accurate stimulus source on `io_uart_rx`.

## Interface

Parameters:
- `DATA_BITS`, 8: data bits per frame, legal 5..9.
- `FIFO_DEPTH`, 16: FIFO entries, power of two, ≥2.
- `DIV_WIDTH`, 16: width of the baud divisor.

Ports:
- `clk`  in  1  system clock.
- `nreset`  in  1  reset, asynchronous assert, active-low.
- `cfg_divisor`  in  DIV_WIDTH  bit time = `cfg_divisor`+1 clocks.
- `cfg_parity`  in  2  00 none, 01 even, 10 odd, 11 none.
- `cfg_stop2`  in  1  1 = two stop bits, 0 = one stop bit.
- `in_valid`  in  1  push request.
- `in_ready`  out  1  FIFO not full.
- `in_data`  in  DATA_BITS  word to send, LSB first on the line.
- `in_inject_parity`  in  1  invert this frame's parity bit.
- `in_inject_framing`  in  1  drive this frame's first stop bit low.
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  a frame is on the line.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  queued words, excluding the frame in flight.

## Operation

- FIFO entry layout: {`in_inject_framing`, `in_inject_parity`, `in_data`}.
  - Push on `in_valid & in_ready`.
  - `in_ready` = !full. It does not depend on a same-cycle pop.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE:
  - `tx`=1.
  - If the FIFO is non-empty: pop, latch the entry, latch `cfg_*`, go to START.
  - `cfg_*` changes take effect only at frame start.
- START:
  - `tx`=0 for one bit time, then go to DATA.
- DATA:
  - Send bit index 0..DATA_BITS-1, each for one bit time.
  - After the last bit go to PARITY if parity is enabled, else STOP1.
- PARITY:
  - Even: `tx` = ^data. Odd: `tx` = ~^data.
  - XOR the value with the latched inject_parity.
- STOP1:
  - `tx` = ~inject_framing.
  - Go to STOP2 if `cfg_stop2`, else end the frame.
- STOP2:
  - `tx`=1, always; injection never touches STOP2.
- End of frame:
  - FIFO non-empty: pop and enter START on the same edge, with no idle cycle between frames.
  - FIFO empty: go to IDLE.
- Bit timer: counts 0..latched divisor, advancing the bit on terminal count. Divisor 0 gives a 1-clock bit.
- inject_parity has no effect when parity is disabled.
- `busy`=1 in every state except IDLE.

## Timing

- Reset values: `tx`=1, `busy`=0, `in_ready`=1, `fifo_level`=0. FSM goes to IDLE, FIFO is emptied, bit timer cleared.
- Reset mid-frame: `tx` goes high asynchronously and the frame is abandoned. No partial frame resumes after release.
- Latency: word accepted at edge k into an empty FIFO with the FSM in IDLE gives `tx`=0 and `busy`=1 after edge k+1.
- `fifo_level`:
  - Push at edge k with no pop: level +1 after edge k.
  - Push and pop on the same edge: level unchanged.
- Frame length: (1 + DATA_BITS + P + S)·(D+1) clocks, where P ∈{0,1} is parity enabled, S∈{1,2} is stop bits, D = latched divisor.
- All outputs are registered; `tx` has no combinational path from any input.
- Full FIFO: `in_ready`=0, and a push attempt is ignored with no overwrite. `in_ready` returns to 1 on the edge after a pop.
- Pointer wrap: pointers are log2(DEPTH)+1 bits; full/empty are decided by the MSB compare.

## Test plan

- Reset, then push 0xA5 with divisor=1, even parity, 1 stop, DATA_BITS=8 -> `tx` low 1 cycle after push. Line sequence 0,1,0,1,0,0,1,0,1,0,1 with each bit 2 cycles (22 cycles). `busy` falls after the last stop bit.
- Odd parity plus `cfg_stop2`, push 0x00 -> parity bit 1, two stop bits high. Frame is 12 bit times.
- Push 0x01 with inject_parity, even parity -> parity bit 0 instead of 1. Next word 0x01 without the flag -> parity bit 1.
- Push 0xFF with inject_framing -> STOP1 low for exactly D+1 cycles. The next frame's start bit follows immediately, and its data is sent intact.
- Push 17 words back-to-back with DEPTH=16 and divisor=3:
  - `in_ready` deasserts when full; an extra push while full is dropped.
  - All accepted words appear in order with no idle gap.
  - `fifo_level` reaches 16 then decrements to 0.
- Assert `nreset` mid-DATA -> `tx`=1 immediately, `fifo_level`=0, `busy`=0. The first push after release produces a full, clean frame.

Source files
------------

// File: rtl/uart_tx_frame_gen.sv
// UART frame transmitter with a byte FIFO, programmable divisor/parity/stop
// bits, and per-word parity/framing fault injection.
module uart_tx_frame_gen #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_WIDTH  = 16
) (
   input  logic                            clk,
   input  logic                            nreset,
   input  logic [DIV_WIDTH-1:0]            cfg_divisor,
   input  logic [1:0]                      cfg_parity,
   input  logic                            cfg_stop2,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [DATA_BITS-1:0]            in_data,
   input  logic                            in_inject_parity,
   input  logic                            in_inject_framing,
   output logic                            tx,
   output logic                            busy,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = DATA_BITS + 2;
   localparam int BW = $clog2(DATA_BITS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP1,
      S_STOP2
   } state_t;

   logic [EW-1:0]        mem_q [FIFO_DEPTH];
   logic [AW:0]          wr_q, rd_q;
   logic                 full, empty, push, pop;
   logic [EW-1:0]        head;

   state_t               state_q, state_d;
   logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
   logic [DIV_WIDTH-1:0] div_q, div_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 injp_q, injp_d;
   logic                 injf_q, injf_d;
   logic [1:0]           par_q, par_d;
   logic                 stop2_q, stop2_d;
   logic                 tx_q, tx_d;
   logic                 busy_q, busy_d;
   logic                 tick, par_en, frame_end;

   // Full when the wrap bits differ but the index bits match.
   assign full       = (wr_q[AW] != rd_q[AW]) &&
                       (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign empty      = (wr_q == rd_q);
   assign push       = in_valid & ~full;
   assign head       = mem_q[rd_q[AW-1:0]];
   assign in_ready   = ~full;
   assign fifo_level = wr_q - rd_q;
   assign tx         = tx_q;
   assign busy       = busy_q;

   assign tick   = (cnt_q == div_q);
   assign par_en = par_q[0] ^ par_q[1];

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_q[AW-1:0]] <= {in_inject_framing, in_inject_parity, in_data};
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (push) wr_q <= wr_q + (AW+1)'(1);
         if (pop)  rd_q <= rd_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         div_q   <= '0;
         bit_q   <= '0;
         data_q  <= '0;
         injp_q  <= 1'b0;
         injf_q  <= 1'b0;
         par_q   <= 2'b00;
         stop2_q <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         data_q  <= data_d;
         injp_q  <= injp_d;
         injf_q  <= injf_d;
         par_q   <= par_d;
         stop2_q <= stop2_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      div_d     = div_q;
      bit_d     = bit_q;
      data_d    = data_q;
      injp_d    = injp_q;
      injf_d    = injf_q;
      par_d     = par_q;
      stop2_d   = stop2_q;
      pop       = 1'b0;
      frame_end = 1'b0;

      if (state_q != S_IDLE) begin
         cnt_d = tick ? '0 : cnt_q + DIV_WIDTH'(1);
      end

      unique case (state_q)
         S_IDLE: begin
            pop = ~empty;
         end
         S_START: begin
            if (tick) begin
               state_d = S_DATA;
               bit_d   = '0;
            end
         end
         S_DATA: begin
            if (tick) begin
               if (bit_q == BW'(DATA_BITS - 1)) begin
                  state_d = par_en ? S_PARITY : S_STOP1;
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end
         end
         S_PARITY: begin
            if (tick) state_d = S_STOP1;
         end
         S_STOP1: begin
            if (tick) begin
               if (stop2_q) state_d = S_STOP2;
               else         frame_end = 1'b1;
            end
         end
         S_STOP2: begin
            if (tick) frame_end = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      if (frame_end) begin
         state_d = S_IDLE;
         pop     = ~empty;
      end

      // Frame start: config is sampled only here.
      if (pop) begin
         state_d                  = S_START;
         cnt_d                    = '0;
         {injf_d, injp_d, data_d} = head;
         div_d                    = cfg_divisor;
         par_d                    = cfg_parity;
         stop2_d                  = cfg_stop2;
      end
   end

   // Line level is computed from next state so tx is a pure register.
   always_comb begin
      tx_d   = 1'b1;
      busy_d = (state_d != S_IDLE);
      unique case (state_d)
         S_IDLE:   tx_d = 1'b1;
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = data_d[bit_d];
         S_PARITY: tx_d = ((par_d == 2'b10) ? ~(^data_d) : ^data_d) ^ injp_d;
         S_STOP1:  tx_d = ~injf_d;
         S_STOP2:  tx_d = 1'b1;
         default:  tx_d = 1'b1;
      endcase
   end

endmodule
